down_timer: RTL and testbench

Loadable synchronous down-counting interval timer with prescaler, pause control and optional auto-reload. It counts toward terminal count where the up-counters count toward 1111. It consumes the same ENP/ENT enable pair and cascade conventions as the counter library. It produces a one-cycle DONE pulse on expiry for sequencing logic downstream.

---
 rtl/down_timer_if.sv | 28 ++
 rtl/down_timer.sv | 69 ++++++
 tb/tb_down_timer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/down_timer_if.sv
// Control/status bundle of the down-counting interval timer.
// master = the sequencing logic that loads and enables the timer, slave = the timer.
interface down_timer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] D;
    logic             LOAD;
    logic             ENP;
    logic             ENT;
    logic             AUTO;
    logic [WIDTH-1:0] Q;
    logic             BUSY;
    logic             DONE;
    logic             BORROW;
    logic             dbg_run;   // FSM state for checkers: 1 = RUN, 0 = IDLE

    // All inputs are level signals sampled on the rising clock edge; there is no
    // valid/ready pairing. LOAD is a one-cycle command, DONE a one-cycle response.
    modport master (
        output D, LOAD, ENP, ENT, AUTO,
        input  Q, BUSY, DONE, BORROW, dbg_run
    );

    modport slave (
        input  D, LOAD, ENP, ENT, AUTO,
        output Q, BUSY, DONE, BORROW, dbg_run
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting interval timer with prescaler, ENP/ENT pause and optional
// auto-reload; pulses DONE for one cycle when the count expires.
module down_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    down_timer_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [PW-1:0]    p_cnt;
    logic             done_r;
    logic             en;

    assign en = bus.ENP && bus.ENT;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= IDLE;
            q_r    <= '0;
            r_r    <= '0;
            p_cnt  <= '0;
            done_r <= 1'b0;
        end else if (bus.LOAD) begin
            // A restart discards any partial prescale; a zero interval never runs.
            q_r    <= bus.D;
            r_r    <= bus.D;
            p_cnt  <= '0;
            done_r <= 1'b0;
            state  <= (bus.D != '0) ? RUN : IDLE;
        end else begin
            done_r <= 1'b0;
            if (state == RUN && en) begin
                if (p_cnt != P_LAST) begin
                    p_cnt <= p_cnt + 1'b1;
                end else begin
                    p_cnt <= '0;
                    if (q_r == ONE) begin
                        // Expiry: auto-reload jumps straight back to R so Q never shows 0.
                        done_r <= 1'b1;
                        if (bus.AUTO) begin
                            q_r <= r_r;
                        end else begin
                            q_r   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        q_r <= q_r - 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Q       = q_r;
    assign bus.BUSY    = (state == RUN);
    assign bus.DONE    = done_r;
    assign bus.BORROW  = bus.ENT && (q_r == '0);
    assign bus.dbg_run = (state == RUN);
endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: a vector table on a PRESCALE=1 instance and hand-written
// prescale/pause/random-interval sequences on a PRESCALE=4 instance.
module tb_down_timer;
  localparam int W  = 8;
  localparam int NV = 33;

  logic CLK = 1'b0;
  logic CLR1;
  logic CLR4;

  always #5 CLK = ~CLK;

  down_timer_if #(.WIDTH(W)) bus1 ();
  down_timer_if #(.WIDTH(W)) bus4 ();

  down_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (.CLK(CLK), .CLR(CLR1), .bus(bus1.slave));
  down_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (.CLK(CLK), .CLR(CLR4), .bus(bus4.slave));

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] d;
    logic         enp;
    logic         ent;
    logic         au;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         borrow;
  } vec_t;

  vec_t vecs [NV];
  logic [W+2:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic clr, input logic load, input logic [W-1:0] d,
                              input logic enp, input logic ent, input logic au,
                              input logic [W-1:0] q, input logic busy, input logic done,
                              input logic borrow);
    vec_t v;
    v.clr = clr; v.load = load; v.d = d; v.enp = enp; v.ent = ent; v.au = au;
    v.q = q; v.busy = busy; v.done = done; v.borrow = borrow;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expectation at the edge, compare at the negedge.
  task automatic cyc(input bit sel4, input logic clr, input logic load, input logic [W-1:0] d,
                     input logic enp, input logic ent, input logic au,
                     input logic [W-1:0] eq, input logic eb, input logic ed, input logic ebr,
                     input string nm);
    logic [W+2:0] e;
    if (sel4) begin
      CLR4 = clr; bus4.LOAD = load; bus4.D = d; bus4.ENP = enp; bus4.ENT = ent; bus4.AUTO = au;
    end else begin
      CLR1 = clr; bus1.LOAD = load; bus1.D = d; bus1.ENP = enp; bus1.ENT = ent; bus1.AUTO = au;
    end
    @(posedge CLK);
    exp_q.push_back({eq, eb, ed, ebr});
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty got=0 exp=1", nm);
    end else begin
      e = exp_q.pop_front();
      if (sel4) begin
        cmp({nm, ".q"},      bus4.Q,                e[W+2:3]);
        cmp({nm, ".busy"},   W'(bus4.BUSY),         W'(e[2]));
        cmp({nm, ".done"},   W'(bus4.DONE),         W'(e[1]));
        cmp({nm, ".borrow"}, W'(bus4.BORROW),       W'(e[0]));
        cmp({nm, ".state"},  W'(bus4.dbg_run),      W'(e[2]));
      end else begin
        cmp({nm, ".q"},      bus1.Q,                e[W+2:3]);
        cmp({nm, ".busy"},   W'(bus1.BUSY),         W'(e[2]));
        cmp({nm, ".done"},   W'(bus1.DONE),         W'(e[1]));
        cmp({nm, ".borrow"}, W'(bus1.BORROW),       W'(e[0]));
        cmp({nm, ".state"},  W'(bus1.dbg_run),      W'(e[2]));
      end
    end
  endtask

  initial begin
    //                clr load d  enp ent au    q  busy done borrow
    vecs[0]  = mk(1, 0, 0, 1, 1, 0,   0, 0, 0, 1);  // reset
    vecs[1]  = mk(1, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 3, 1, 1, 0,   3, 1, 0, 0);  // load 3
    vecs[3]  = mk(0, 0, 0, 1, 1, 0,   2, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1, 0,   1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);  // expiry
    vecs[6]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0);  // ENT gates BORROW
    vecs[8]  = mk(0, 1, 2, 1, 1, 1,   2, 1, 0, 0);  // auto-reload 2
    vecs[9]  = mk(0, 0, 0, 1, 1, 1,   1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 1,   2, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 1, 1, 1,   1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 1, 1,   2, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 1, 1,   1, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);  // AUTO dropped at expiry
    vecs[15] = mk(0, 1, 3, 1, 1, 0,   3, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 1, 0,   2, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 1, 1, 0,   1, 1, 0, 0);
    vecs[18] = mk(0, 1, 5, 1, 1, 0,   5, 1, 0, 0);  // LOAD wins over expiry
    vecs[19] = mk(0, 0, 0, 1, 1, 0,   4, 1, 0, 0);
    vecs[20] = mk(0, 1, 0, 1, 1, 0,   0, 0, 0, 1);  // load 0: idle, no DONE
    vecs[21] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    vecs[23] = mk(0, 1, 9, 1, 1, 0,   9, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 1, 1, 0,   8, 1, 0, 0);
    vecs[25] = mk(0, 0, 0, 1, 1, 0,   7, 1, 0, 0);
    vecs[26] = mk(1, 1, 4, 1, 1, 0,   0, 0, 0, 1);  // CLR beats LOAD
    vecs[27] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);  // stays idle
    vecs[28] = mk(0, 1, 2, 1, 1, 0,   2, 1, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 1, 0,   2, 1, 0, 0);  // ENP pause
    vecs[30] = mk(0, 0, 0, 1, 1, 0,   1, 1, 0, 0);
    vecs[31] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1);
    vecs[32] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1);

    CLR1 = 1'b1; bus1.LOAD = 1'b0; bus1.D = '0; bus1.ENP = 1'b1; bus1.ENT = 1'b1; bus1.AUTO = 1'b0;
    CLR4 = 1'b1; bus4.LOAD = 1'b0; bus4.D = '0; bus4.ENP = 1'b1; bus4.ENT = 1'b1; bus4.AUTO = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < NV; i++) begin
      cyc(1'b0, vecs[i].clr, vecs[i].load, vecs[i].d, vecs[i].enp, vecs[i].ent, vecs[i].au,
          vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].borrow, $sformatf("v%0d", i));
    end

    // PRESCALE=4: reset, then D=2 loaded at edge 0 expires at edge 8.
    cyc(1'b1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, "p4_rst");
    cyc(1'b1, 0, 1, 2, 1, 1, 0, 2, 1, 0, 0, "p4_e0");
    for (int e = 1; e <= 9; e++) begin
      logic [W-1:0] eq;
      eq = (e < 4) ? W'(2) : (e < 8) ? W'(1) : W'(0);
      cyc(1'b1, 0, 0, 0, 1, 1, 0, eq, (e < 8), (e == 8), (eq == 0), $sformatf("p4_e%0d", e));
    end

    // Pause: ENT low for edges 2..4 pushes the expiry from edge 8 to edge 11.
    cyc(1'b1, 0, 1, 2, 1, 1, 0, 2, 1, 0, 0, "pz_e0");
    for (int e = 1; e <= 12; e++) begin
      logic [W-1:0] eq;
      logic         ent;
      ent = !(e >= 2 && e <= 4);
      eq  = (e < 7) ? W'(2) : (e < 11) ? W'(1) : W'(0);
      cyc(1'b1, 0, 0, 0, 1, ent, 0, eq, (e < 11), (e == 11), ent && (eq == 0),
          $sformatf("pz_e%0d", e));
    end

    // Random intervals: expiry exactly N*4 enabled edges after the load.
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, 5);
      cyc(1'b1, 0, 1, W'(n), 1, 1, 0, W'(n), 1, 0, 0, $sformatf("rn%0d_e0", t));
      for (int e = 1; e <= n * 4 + 1; e++) begin
        logic [W-1:0] eq;
        eq = (e < n * 4) ? W'(n - e / 4) : W'(0);
        cyc(1'b1, 0, 0, 0, 1, 1, 0, eq, (e < n * 4), (e == n * 4), (eq == 0),
            $sformatf("rn%0d_e%0d", t, e));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
